// File: rtl/input_stream_feeder.sv
// Host-side stream source: buffers host words in a small FIFO and replays each
// one as INDEX_AMOUNT contiguous (index, value, enable) beats for the first cell.
module input_stream_feeder #(
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_AMOUNT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DATA_WIDTH-1:0]              in_value,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [DATA_WIDTH-1:0]              output_index,
  output logic [DATA_WIDTH-1:0]              output_value,
  output logic                               output_enable,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               busy
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0]         DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] IDX_LAST = DATA_WIDTH'(INDEX_AMOUNT-1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [0:0]            state;
  logic                  push, pop, last_beat, fifo_nonempty;

  // Ready looks only at the registered count, so a same-edge pop never opens
  // a slot early and a full FIFO can never be overwritten.
  assign in_ready      = rst_n && (fifo_count < DEPTH_C);
  assign fifo_nonempty = (fifo_count != '0);
  assign push          = in_valid && in_ready;
  assign last_beat     = (state == S_EMIT) && (output_index == IDX_LAST);
  assign pop           = fifo_nonempty && ((state == S_IDLE) || last_beat);
  assign busy          = (state == S_EMIT) || fifo_nonempty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_value;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      output_index  <= '0;
      output_value  <= '0;
      output_enable <= 1'b0;
    end else if (state == S_IDLE) begin
      if (pop) begin
        output_value  <= mem[rd_ptr];
        output_index  <= '0;
        output_enable <= 1'b1;
        state         <= S_EMIT;
      end
    end else begin
      if (last_beat) begin
        output_index <= '0;
        // Chain straight into the next word when one is queued; otherwise
        // drop enable and keep the last value on the bus.
        if (pop) begin
          output_value <= mem[rd_ptr];
        end else begin
          output_enable <= 1'b0;
          state         <= S_IDLE;
        end
      end else begin
        output_index <= output_index + DATA_WIDTH'(1);
      end
    end
  end

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= DEPTH_C);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && fifo_count == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && fifo_count == DEPTH_C));

endmodule

// File: tb/tb_input_stream_feeder.sv
// Two feeders (INDEX_AMOUNT 4 and 1) checked every cycle against a schedule
// model: each accepted word gets a start edge, beats follow from arithmetic.
module tb_input_stream_feeder;
  localparam int DEPTH = 4;

  logic              clk, rst_n;
  logic [1:0]        in_valid;
  logic [31:0]       in_value [2];
  wire  [1:0]        in_ready, output_enable, busy;
  wire  [31:0]       output_index [2];
  wire  [31:0]       output_value [2];
  wire  [2:0]        fifo_count [2];

  int n_chk, n_fail;

  input_stream_feeder #(.DATA_WIDTH(32), .INDEX_AMOUNT(4), .FIFO_DEPTH(DEPTH)) u_ia4 (
    .clk(clk), .rst_n(rst_n), .in_value(in_value[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .output_index(output_index[0]), .output_value(output_value[0]),
    .output_enable(output_enable[0]), .fifo_count(fifo_count[0]), .busy(busy[0]));

  input_stream_feeder #(.DATA_WIDTH(32), .INDEX_AMOUNT(1), .FIFO_DEPTH(DEPTH)) u_ia1 (
    .clk(clk), .rst_n(rst_n), .in_value(in_value[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .output_index(output_index[1]), .output_value(output_value[1]),
    .output_enable(output_enable[1]), .fifo_count(fifo_count[1]), .busy(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ia(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[k=%0d] at %0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  // Model: every accepted word starts at edge s = max(push_edge+1, prev_start+IA)
  // and owns edges s..s+IA-1. Occupancy after edge t = words with s > t.
  typedef struct { int k; int s; logic [31:0] v; } ent_t;
  ent_t ents[$];
  int   e;
  int   last_s [2];

  function automatic int cnt_after(input int k, input int t);
    int c;
    c = 0;
    foreach (ents[i]) if (ents[i].k == k && ents[i].s > t) c++;
    return c;
  endfunction

  initial begin
    int s;
    e = 0;
    last_s[0] = -1000;
    last_s[1] = -1000;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        ents.delete();
        last_s[0] = -1000;
        last_s[1] = -1000;
      end else begin
        e++;
        for (int k = 0; k < 2; k++) begin
          if (in_valid[k] && cnt_after(k, e-1) < DEPTH) begin
            s = (e + 1 > last_s[k] + ia(k)) ? e + 1 : last_s[k] + ia(k);
            ents.push_back('{k: k, s: s, v: in_value[k]});
            last_s[k] = s;
          end
        end
      end
    end
  end

  initial begin
    logic        en_x;
    int          idx_x, cnt_x, best;
    logic [31:0] val_x;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        en_x = 1'b0; idx_x = 0; val_x = '0; cnt_x = 0; best = -2000;
        foreach (ents[i]) begin
          if (ents[i].k == k) begin
            if (ents[i].s > e) cnt_x++;
            else begin
              if (ents[i].s > best) begin best = ents[i].s; val_x = ents[i].v; end
              if (e < ents[i].s + ia(k)) begin en_x = 1'b1; idx_x = e - ents[i].s; end
            end
          end
        end
        chk("enable", k, 32'(output_enable[k]), 32'(en_x));
        chk("index",  k, output_index[k], idx_x);
        chk("value",  k, output_value[k], val_x);
        chk("count",  k, 32'(fifo_count[k]), cnt_x);
        chk("busy",   k, 32'(busy[k]), 32'(en_x || cnt_x > 0));
        chk("ready",  k, 32'(in_ready[k]), 32'(rst_n && cnt_x < DEPTH));
      end
    end
  end

  // Offers words base..base+n-1 in order; while not ready, optionally keeps
  // valid high with junk data that must never be accepted.
  task automatic stream(input int k, input int base, input int n, input bit junk);
    int sent, guard;
    sent = 0; guard = 0;
    while (sent < n && guard < 400) begin
      @(negedge clk); #1; guard++;
      if (in_ready[k]) begin
        in_valid[k] = 1'b1; in_value[k] = base + sent; sent++;
      end else begin
        in_valid[k] = junk; in_value[k] = $urandom;
      end
    end
    @(negedge clk); #1;
    in_valid[k] = 1'b0;
    if (sent < n) chk("stream_timeout", k, sent, n);
  endtask

  initial begin
    int g;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; in_valid = '0; in_value[0] = '0; in_value[1] = '0;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_enable", k, 32'(output_enable[k]), 0);
      chk("rst_count",  k, 32'(fifo_count[k]), 0);
      chk("rst_ready",  k, 32'(in_ready[k]), 0);
    end
    #1 rst_n = 1'b1;

    // Two words back to back: literal 8-beat stream
    @(negedge clk); #1 in_valid[0] = 1'b1; in_value[0] = 1;
    @(negedge clk); #1 in_value[0] = 2;
    @(negedge clk); #1 in_valid[0] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk("t1_enable", 0, 32'(output_enable[0]), 1);
      chk("t1_index",  0, output_index[0], j % 4);
      chk("t1_value",  0, output_value[0], 1 + j / 4);
      @(negedge clk); #1;
    end
    chk("t1_enable_end", 0, 32'(output_enable[0]), 0);
    chk("t1_busy_end",   0, 32'(busy[0]), 0);
    chk("t1_value_hold", 0, output_value[0], 2);

    // Held valid against a filling FIFO
    stream(0, 10, 6, 1'b0);
    repeat (30) @(negedge clk);

    // Isolated words with an idle gap
    stream(0, 7, 1, 1'b0);
    repeat (10) @(negedge clk);
    stream(0, 9, 1, 1'b0);
    repeat (8) @(negedge clk);

    // Async reset mid-word with three words queued
    stream(0, 20, 4, 1'b0);
    g = 0;
    while (!(output_enable[0] && output_index[0] == 2) && g < 40) begin
      @(negedge clk); g++;
    end
    chk("t4_reached_idx2", 0, 32'(g < 40), 1);
    chk("t4_queued", 0, 32'(fifo_count[0]), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_enable", 0, 32'(output_enable[0]), 0);
    chk("t4_count",  0, 32'(fifo_count[0]), 0);
    chk("t4_ready",  0, 32'(in_ready[0]), 0);
    chk("t4_index",  0, output_index[0], 0);
    chk("t4_busy",   0, 32'(busy[0]), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    stream(0, 5, 1, 1'b0);
    repeat (8) @(negedge clk);

    // One beat per word, continuous valid
    stream(1, 1, 8, 1'b0);
    repeat (5) @(negedge clk);

    // Junk offered while full
    stream(0, 100, 10, 1'b1);
    repeat (45) @(negedge clk);

    // Random traffic on both feeders
    repeat (400) begin
      @(negedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        in_valid[k] = ($urandom_range(0, 3) != 0);
        in_value[k] = $urandom;
      end
    end
    @(negedge clk); #1 in_valid = '0;
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/input_stream_feeder.md
Name: input_stream_feeder

Overview:
- Transmit end of the index/value/enable stream that drives the first weight_comp_cell of a layer chain.
- Accepts raw input values from the host over a valid/ready handshake and buffers them in a small FIFO.
- Replays each value for INDEX_AMOUNT consecutive cycles with output_index stepping 0..INDEX_AMOUNT-1 and output_enable high. This is the same stream shape relu_cell produces between layers, but sourced from the host side.

Parameters:
- DATA_WIDTH, 32, width of values and indices.
- INDEX_AMOUNT, 4, number of index beats emitted per value; must equal WEIGHT_AMOUNT of the downstream cells; legal range 1..2^DATA_WIDTH-1.
- FIFO_DEPTH, 4, input buffer entries; power of two, at least 2.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_value, input, DATA_WIDTH, host data word.
- in_valid, input, 1, host word present.
- in_ready, output, 1, FIFO can accept a word.
- output_index, output, DATA_WIDTH, weight index for the current beat.
- output_value, output, DATA_WIDTH, value being broadcast.
- output_enable, output, 1, beat valid.
- fifo_count, output, $clog2(FIFO_DEPTH+1), occupied FIFO entries.
- busy, output, 1, high while emitting or while the FIFO is non-empty.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (asserted at any time, including mid-value or mid-beat):
  - output_enable=0, output_index=0, output_value=0, fifo_count=0, busy=0, in_ready=0; FIFO pointers cleared; contents discarded.
  - On release, in_ready rises combinationally from the cleared count.
- in_ready = rst_n && (fifo_count < FIFO_DEPTH). It depends on registered count only, never on a same-cycle pop, so no push occurs when full.
- Push: in_valid && in_ready at a rising edge writes in_value at the write pointer. Pointers wrap modulo FIFO_DEPTH. When in_ready=0, in_valid is ignored and no data is lost or duplicated; the host holds the word.
- Emitter FSM, two states:
  - IDLE: output_enable=0. If the registered fifo_count>0, pop at the edge: output_value<=head, output_index<=0, output_enable<=1, go to EMIT.
  - EMIT: each edge, output_index increments.
    - When output_index==INDEX_AMOUNT-1 and fifo_count>0: pop the next head in the same edge, output_index<=0, stay in EMIT. No bubble between values.
    - When output_index==INDEX_AMOUNT-1 and fifo_count==0: output_enable<=0, output_index<=0, go to IDLE; output_value holds its last value.
  - INDEX_AMOUNT=1: every EMIT beat is a last beat; one value per cycle.
- Latency: a word pushed into an empty FIFO at edge N appears with index 0 and enable high after edge N+1.
- Throughput: one value per INDEX_AMOUNT cycles.
- Simultaneous push and pop at one edge: fifo_count unchanged. The popped entry is always the oldest, and the pushed word is never the one popped at that edge.
- fifo_count is never negative and never exceeds FIFO_DEPTH. Both are checked with assertions in simulation.
- busy = (state==EMIT) || (fifo_count>0).
- Outputs change only on clk edges or asynchronous reset. The downstream interface has no backpressure: once output_enable is high, beats are emitted unconditionally.

Test Plan:
1. Reset release, host pushes 1 then 2 back-to-back, INDEX_AMOUNT=4 -> 8 contiguous enable cycles: (idx,val)=(0,1),(1,1),(2,1),(3,1),(0,2),(1,2),(2,2),(3,2), then enable=0 and busy=0. Feeding this into the 3-layer chain yields second-ReLU values 97,124,41,164 / 194,248,82,328 and argmax 0 twice.
2. in_valid held high with values 10..15 from an empty FIFO, depth 4 -> in_ready drops after fifo_count reaches 4. Words 10..15 are each emitted exactly once, in order, 4 beats each. Total 24 enable cycles with no gaps.
3. Push 7, idle 10 cycles, push 9 -> value 7 for 4 beats, enable low for 6 cycles, value 9 beginning 2 edges after its push edge. output_value holds 7 during the gap.
4. rst_n pulled low asynchronously at output_index=2 with 3 words queued -> enable=0, fifo_count=0, in_ready=0 immediately, no clock edge required. After release, one new push of 5 emits only value 5.
5. INDEX_AMOUNT=1, in_valid continuously high with values 1..8 -> one beat per cycle, index always 0. fifo_count stays at 1 after the first push; in_ready never deasserts.
6. Host drives in_valid=1 while in_ready=0 with a changing value on a full FIFO -> the ignored values never appear on output_value, and the FIFO-order check passes.
